// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter driving the shared open-drain PS2_CLK/PS2_DAT pins.
// Define PS2_TX_TIMEOUT_EN to add a watchdog on the device clock during the frame.
module ps2_host_tx #(
  parameter int unsigned CLK_FREQ       = 50_000_000,
  parameter int unsigned INHIBIT_CYCLES = 5_000,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic       Clock,
  input  logic       nReset,
  input  logic [7:0] cmd,
  input  logic       send,
  output logic       busy,
  output logic       done,
  output logic       error,
  inout  wire        PS2_CLK,
  inout  wire        PS2_DAT
);

  // state     | meaning
  // IDLE      | bus released, waiting for send
  // INHIBIT   | PS2_CLK held low; start bit driven on the last cycle
  // REQ       | PS2_CLK released, start bit held, request to send
  // SHIFT     | data, parity and stop bits advanced on each device clock fall
  // ACK       | waiting for fall 11 to sample the device acknowledge
  // DONE      | done pulse
  // WAITIDLE  | waiting for both lines high for two consecutive cycles
  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_REQ, S_SHIFT, S_ACK, S_DONE, S_WAITIDLE
  } state_t;

  // Never inhibit for less than 100 us, whatever the caller asked for.
  localparam int unsigned MIN_INHIBIT = CLK_FREQ / 10_000;
  localparam int unsigned INH_EFF     = (INHIBIT_CYCLES < MIN_INHIBIT) ? MIN_INHIBIT :
                                        (INHIBIT_CYCLES == 0) ? 1 : INHIBIT_CYCLES;
  localparam int unsigned INH_W       = (INH_EFF > 1) ? $clog2(INH_EFF) : 1;
  localparam logic [INH_W-1:0] INH_LOAD = INH_W'(INH_EFF - 1);

  generate
    if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > (1 << 20)) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be in 1..2^20");
    end
  endgenerate

  state_t           state, state_d;
  logic [9:0]       frame, frame_d;
  logic [INH_W-1:0] inh_cnt, inh_cnt_d;
  logic [3:0]       bit_cnt, bit_cnt_d;
  logic             idle_seen, idle_seen_d;
  logic             clk_drv, clk_drv_d;
  logic             dat_drv, dat_drv_d;
  logic             done_d, err_d;
  logic             clk_m, clk_s0, clk_s1, dat_m, dat_s;
  logic             fall;
  logic             timeout;

  // Synchronisers start high so reset never fakes a falling edge.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      clk_m  <= 1'b1;
      clk_s0 <= 1'b1;
      clk_s1 <= 1'b1;
      dat_m  <= 1'b1;
      dat_s  <= 1'b1;
    end else begin
      clk_m  <= PS2_CLK;
      clk_s0 <= clk_m;
      clk_s1 <= clk_s0;
      dat_m  <= PS2_DAT;
      dat_s  <= dat_m;
    end
  end

  assign fall = clk_s1 & ~clk_s0;

`ifdef PS2_TX_TIMEOUT_EN
  localparam logic [19:0] WDOG_LOAD = 20'(TIMEOUT_CYCLES - 1);
  logic [19:0] wdog;
  logic        wdog_run, wdog_clr;

  assign wdog_run = (state == S_REQ) || (state == S_SHIFT) || (state == S_ACK);
  assign wdog_clr = fall || (state == S_INHIBIT && inh_cnt == '0);

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset)                      wdog <= '0;
    else if (wdog_clr)                wdog <= WDOG_LOAD;
    else if (wdog_run && wdog != '0)  wdog <= wdog - 20'd1;
  end

  assign timeout = wdog_run && !fall && (wdog == '0);
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state     <= S_IDLE;
      frame     <= '0;
      inh_cnt   <= '0;
      bit_cnt   <= '0;
      idle_seen <= 1'b0;
      clk_drv   <= 1'b0;
      dat_drv   <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      state     <= state_d;
      frame     <= frame_d;
      inh_cnt   <= inh_cnt_d;
      bit_cnt   <= bit_cnt_d;
      idle_seen <= idle_seen_d;
      clk_drv   <= clk_drv_d;
      dat_drv   <= dat_drv_d;
      done      <= done_d;
      error     <= err_d;
    end
  end

  always_comb begin
    state_d     = state;
    frame_d     = frame;
    inh_cnt_d   = inh_cnt;
    bit_cnt_d   = bit_cnt;
    idle_seen_d = idle_seen;
    clk_drv_d   = 1'b0;
    dat_drv_d   = 1'b0;
    done_d      = 1'b0;
    err_d       = 1'b0;
    case (state)
      S_IDLE: begin
        if (send) begin
          state_d   = S_INHIBIT;
          frame_d   = {1'b1, ~^cmd, cmd};
          inh_cnt_d = INH_LOAD;
          bit_cnt_d = '0;
          clk_drv_d = 1'b1;
          dat_drv_d = (INH_EFF == 1);
        end
      end
      S_INHIBIT: begin
        clk_drv_d = 1'b1;
        if (inh_cnt == '0) begin
          state_d   = S_REQ;
          clk_drv_d = 1'b0;
          dat_drv_d = 1'b1;
        end else begin
          inh_cnt_d = inh_cnt - 1'b1;
          dat_drv_d = (inh_cnt == INH_W'(1));
        end
      end
      S_REQ: begin
        dat_drv_d = 1'b1;
        bit_cnt_d = '0;
        state_d   = S_SHIFT;
      end
      S_SHIFT: begin
        dat_drv_d = dat_drv;
        if (fall) begin
          dat_drv_d = ~frame[0];
          frame_d   = {1'b0, frame[9:1]};
          bit_cnt_d = bit_cnt + 4'd1;
          if (bit_cnt == 4'd9) state_d = S_ACK;
        end
      end
      S_ACK: begin
        if (fall) begin
          bit_cnt_d   = (bit_cnt == 4'd11) ? bit_cnt : bit_cnt + 4'd1;
          idle_seen_d = 1'b0;
          if (!dat_s) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_WAITIDLE;
            err_d   = 1'b1;
          end
        end
      end
      S_DONE: begin
        state_d     = S_WAITIDLE;
        idle_seen_d = 1'b0;
      end
      S_WAITIDLE: begin
        if (clk_s0 && dat_s) begin
          if (idle_seen) state_d = S_IDLE;
          else           idle_seen_d = 1'b1;
        end else begin
          idle_seen_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A stalled device aborts straight to IDLE; WAITIDLE would hang on a dead bus.
    if (timeout) begin
      state_d   = S_IDLE;
      clk_drv_d = 1'b0;
      dat_drv_d = 1'b0;
      done_d    = 1'b0;
      err_d     = 1'b1;
    end
  end

  assign busy    = (state != S_IDLE);
  assign PS2_CLK = clk_drv ? 1'b0 : 1'bz;
  assign PS2_DAT = dat_drv ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model clocks frames out of the host and checks
// each bit against a frame computed from the command byte.
module tb_ps2_host_tx;

  localparam int unsigned CLK_FREQ = 100_000;
  localparam int unsigned INH      = 20;
  localparam int unsigned TMO      = 600;

  logic       Clock  = 1'b0;
  logic       nReset = 1'b0;
  logic [7:0] cmd    = 8'h00;
  logic       send   = 1'b0;
  logic       busy, done, error;
  wire        ps2_clk, ps2_dat;
  logic       dev_clk_low = 1'b0;
  logic       dev_dat_low = 1'b0;

  pullup (ps2_clk);
  pullup (ps2_dat);
  assign ps2_clk = dev_clk_low ? 1'b0 : 1'bz;
  assign ps2_dat = dev_dat_low ? 1'b0 : 1'bz;

  ps2_host_tx #(
    .CLK_FREQ       (CLK_FREQ),
    .INHIBIT_CYCLES (INH),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .Clock   (Clock),
    .nReset  (nReset),
    .cmd     (cmd),
    .send    (send),
    .busy    (busy),
    .done    (done),
    .error   (error),
    .PS2_CLK (ps2_clk),
    .PS2_DAT (ps2_dat)
  );

  always #5 Clock = ~Clock;

  int vectors     = 0;
  int miscompares = 0;
  int done_cnt    = 0;
  int err_cnt     = 0;
  logic done_q1   = 1'b0;
  logic err_q1    = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Wire order: start, data LSB first, odd parity, stop.
  function automatic logic [10:0] model_frame(input logic [7:0] c);
    logic par;
    par = ($countones(c) % 2 == 0);
    return {1'b1, par, c, 1'b0};
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(negedge Clock);
  endtask

  always @(negedge Clock) begin
    if (done)  done_cnt++;
    if (error) err_cnt++;
    check("done_error_exclusive", int'(done & error), 0);
    check("done_width", int'(done & done_q1), 0);
    check("error_width", int'(error & err_q1), 0);
    if (!busy && !dev_clk_low) check("idle_clk_released", int'(ps2_clk), 1);
    if (!busy && !dev_dat_low) check("idle_dat_released", int'(ps2_dat), 1);
    done_q1 = done;
    err_q1  = error;
  end

  // mode: 0 normal, 1 resend at fall 5, 2 reset at fall 6, 3 device stalls after fall 3
  task automatic transfer(input logic [7:0] c, input bit nack, input int mode);
    logic [10:0] fr;
    int          n, nf, d0, e0;
    logic        first_dat, last_dat;
    fr = model_frame(c);
    nf = (mode == 3) ? 3 : 11;
    d0 = done_cnt;
    e0 = err_cnt;
    @(negedge Clock);
    cmd  = c;
    send = 1'b1;
    @(negedge Clock);
    send = 1'b0;
    cmd  = 8'($urandom);
    check("send_latency_clk", int'(ps2_clk), 0);
    check("busy_on_accept", int'(busy), 1);
    n = 0;
    first_dat = ps2_dat;
    last_dat  = ps2_dat;
    while (ps2_clk == 1'b0 && n < 4 * int'(INH)) begin
      last_dat = ps2_dat;
      n++;
      @(negedge Clock);
    end
    check("inhibit_len", n, int'(INH));
    check("inhibit_dat_first", int'(first_dat), 1);
    check("start_bit_in_inhibit", int'(last_dat), 0);
    check("start_bit_req", int'(ps2_dat), int'(fr[0]));

    for (int k = 1; k <= nf; k++) begin
      if (k == 11) dev_dat_low = !nack;
      cycles($urandom_range(6, 12));
      dev_clk_low = 1'b1;
      if (mode == 1 && k == 5) begin
        cmd  = 8'h12;
        send = 1'b1;
        @(negedge Clock);
        send = 1'b0;
      end
      if (mode == 2 && k == 6) begin
        cycles(6);
        check("dat_before_reset", int'(ps2_dat), int'(fr[6]));
        #2;
        dev_clk_low = 1'b0;
        nReset      = 1'b0;
        #1;
        check("reset_clk_released", int'(ps2_clk), 1);
        check("reset_dat_released", int'(ps2_dat), 1);
        check("reset_busy", int'(busy), 0);
        cycles(3);
        nReset = 1'b1;
        cycles(3);
        check("reset_no_pulse", (done_cnt - d0) + (err_cnt - e0), 0);
        return;
      end
      cycles($urandom_range(6, 12));
      if (k <= 10) begin
        check($sformatf("frame_bit%0d_cmd%02h", k, c), int'(ps2_dat), int'(fr[k]));
        check("busy_in_frame", int'(busy), 1);
      end
      dev_clk_low = 1'b0;
    end

    if (mode == 3) begin
      n = 0;
`ifdef PS2_TX_TIMEOUT_EN
      while (err_cnt == e0 && n < int'(TMO) + 100) begin
        n++;
        @(negedge Clock);
      end
      check("timeout_error", err_cnt - e0, 1);
      check("timeout_window", int'(n >= int'(TMO) - 20 && n <= int'(TMO) + 2), 1);
      check("timeout_busy", int'(busy), 0);
      check("timeout_clk", int'(ps2_clk), 1);
      check("timeout_dat", int'(ps2_dat), 1);
      check("timeout_no_done", done_cnt - d0, 0);
`else
      cycles(2 * int'(TMO));
      check("stall_busy_held", int'(busy), 1);
      check("stall_no_error", err_cnt - e0, 0);
      @(negedge Clock);
      nReset = 1'b0;
      cycles(2);
      nReset = 1'b1;
      cycles(2);
      check("stall_reset_busy", int'(busy), 0);
`endif
      return;
    end

    cycles(2);
    dev_dat_low = 1'b0;
    n = 0;
    while (busy && n < 200) begin
      n++;
      @(negedge Clock);
    end
    check("busy_drops", int'(busy), 0);
    check("done_count", done_cnt - d0, nack ? 0 : 1);
    check("error_count", err_cnt - e0, nack ? 1 : 0);
    if (mode == 1) begin
      cycles(30);
      check("resend_dropped", int'(busy), 0);
    end
  endtask

  initial begin
    // 0xED has six ones, so odd parity is 1; 0x01 has one, so parity is 0.
    check("model_frame_ED", int'(model_frame(8'hED)), 32'h7DA);
    check("model_frame_00", int'(model_frame(8'h00)), 32'h600);
    check("model_frame_FF", int'(model_frame(8'hFF)), 32'h7FE);
    check("model_frame_01", int'(model_frame(8'h01)), 32'h402);

    cycles(2);
    check("reset_busy0", int'(busy), 0);
    check("reset_done0", int'(done), 0);
    check("reset_error0", int'(error), 0);
    check("reset_clk_z", int'(ps2_clk), 1);
    check("reset_dat_z", int'(ps2_dat), 1);
    nReset = 1'b1;
    cycles(3);

    transfer(8'hED, 1'b0, 0);
    transfer(8'h00, 1'b0, 0);
    transfer(8'hFF, 1'b0, 0);
    transfer(8'hA5, 1'b1, 0);
    transfer(8'hF4, 1'b0, 1);
    transfer(8'h5A, 1'b0, 2);
    transfer(8'hED, 1'b0, 0);
    transfer(8'h3C, 1'b0, 3);
    cycles(5);
    for (int i = 0; i < 6; i++) begin
      transfer(8'($urandom), ($urandom_range(0, 3) == 0), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: bench did not finish, %0d vectors, %0d miscompares", vectors, miscompares);
    $fatal(1, "bench timeout");
  end

endmodule
